// File: rtl/ntt_ctrl.sv
// ntt_ctrl: in-place radix-2 DIT NTT sequencer, one butterfly per cycle.
// Define NTT_INV_EN to add the inverse input and the inverse-twiddle MSB.
module ntt_ctrl #(
    parameter int LOG_N = 10,
`ifdef NTT_INV_EN
    localparam int TW_W = LOG_N
`else
    localparam int TW_W = LOG_N - 1
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef NTT_INV_EN
    input  logic             inverse,
`endif
    output logic             busy,
    output logic             done,
    output logic [LOG_N-1:0] stage,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_addr_u,
    output logic [LOG_N-1:0] rd_addr_v,
    output logic [TW_W-1:0]  tw_addr,
    output logic             wr_en,
    output logic [LOG_N-1:0] wr_addr_u,
    output logic [LOG_N-1:0] wr_addr_v
);

    localparam int ADDR_W = LOG_N;
    localparam int TL     = LOG_N - 1;

    localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] B_LAST = ADDR_W'((1 << (LOG_N - 1)) - 1);
    localparam logic [ADDR_W-1:0] S_LAST = ADDR_W'(LOG_N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] s_q;
    logic [ADDR_W-1:0] s_d;
    logic [ADDR_W-1:0] b_q;
    logic [ADDR_W-1:0] b_d;
    logic              busy_q;
    logic              done_q;
    logic              rd_en_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] rd_u_q;
    logic [ADDR_W-1:0] rd_v_q;
    logic [ADDR_W-1:0] wr_u_q;
    logic [ADDR_W-1:0] wr_v_q;
    logic [TL-1:0]     tw_q;

    logic [ADDR_W-1:0] half_d;
    logic [ADDR_W-1:0] k_d;
    logic [ADDR_W-1:0] u_d;
    logic [ADDR_W-1:0] v_d;
    logic [TL-1:0]     tw_d;

    // Butterfly index that will be presented in the next cycle.
    always_comb begin
        s_d = '0;
        b_d = '0;
        unique case (state_q)
            IDLE: begin
                s_d = '0;
                b_d = '0;
            end
            RUN: begin
                s_d = s_q;
                b_d = (b_q == B_LAST) ? b_q : b_q + ONE;
            end
            DRAIN: begin
                s_d = (s_q == S_LAST) ? s_q : s_q + ONE;
                b_d = (s_q == S_LAST) ? b_q : '0;
            end
            DONE: begin
                s_d = '0;
                b_d = '0;
            end
        endcase
    end

    always_comb begin
        half_d = ONE << s_d;
        k_d    = b_d & (half_d - ONE);
        u_d    = ((b_d >> s_d) << (s_d + ONE)) | k_d;
        v_d    = u_d + half_d;
        tw_d   = TL'(k_d << (S_LAST - s_d));
    end

`ifdef NTT_INV_EN
    logic inv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inv_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            inv_q <= inverse;
        end
    end

    assign tw_addr = {inv_q, tw_q};
`else
    assign tw_addr = tw_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            rd_u_q  <= '0;
            rd_v_q  <= '0;
            wr_u_q  <= '0;
            wr_v_q  <= '0;
            tw_q    <= '0;
        end else begin
            done_q  <= 1'b0;
            wr_en_q <= rd_en_q;
            wr_u_q  <= rd_u_q;
            wr_v_q  <= rd_v_q;
            s_q     <= s_d;
            b_q     <= b_d;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                        rd_u_q  <= u_d;
                        rd_v_q  <= v_d;
                        tw_q    <= tw_d;
                    end
                end
                RUN: begin
                    if (b_q == B_LAST) begin
                        state_q <= DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        rd_u_q <= u_d;
                        rd_v_q <= v_d;
                        tw_q   <= tw_d;
                    end
                end
                DRAIN: begin
                    // Bubble lets the stage's last write retire before reads.
                    if (s_q == S_LAST) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= RUN;
                        rd_en_q <= 1'b1;
                        rd_u_q  <= u_d;
                        rd_v_q  <= v_d;
                        tw_q    <= tw_d;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    rd_u_q  <= '0;
                    rd_v_q  <= '0;
                    tw_q    <= '0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign stage     = s_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_u = rd_u_q;
    assign rd_addr_v = rd_v_q;
    assign wr_en     = wr_en_q;
    assign wr_addr_u = wr_u_q;
    assign wr_addr_v = wr_v_q;

endmodule
